loa_error_monitor: RTL

Streaming error-characterisation block for the lower-part-OR approximate adder family. It consumes operand pairs over a valid/ready handshake and computes, per pair, both the exact sum and the LOA approximate sum. It accumulates error statistics over a window of 2^LOG2_N samples, then presents one report over a second valid/ready handshake. It is the measurement-side counterpart to the LOA datapath and is used in silicon self-characterisation and in regression benches of the approximate-arithmetic library.

---
 rtl/loa_error_monitor.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/loa_error_monitor.sv
// -----------------------------------------------------------------------------
// loa_error_monitor
//
// Measures how far a lower-part-OR approximate adder (LOA) strays from an
// exact adder. For each operand pair it forms the exact sum and the LOA sum.
// Over a window of 2^LOG2_N accepted pairs it accumulates three statistics:
// the count of non-zero errors, the sum of error distances, and the largest
// error distance. It then offers the result as a single report.
//
// Parameters
//   W       operand / sum width
//   M       LOA lower-part width (the OR region), 1 <= M < W
//   LOG2_N  log2 of the number of samples in one window
//
// Ports
//   clk        clock; all state changes on the rising edge
//   rst_n      asynchronous active-low reset
//   start      begins a window; honoured only in IDLE
//   abort      drops the current window and returns to IDLE
//   in_valid   operand pair valid
//   in_ready   block accepts an operand pair (high only in RUN)
//   a, b       operands
//   rpt_valid  report valid (high only in REPORT)
//   rpt_ready  report consumed
//   err_count  number of samples whose error distance is non-zero
//   ed_sum     sum of the error distances
//   ed_max     largest error distance in the window
//   busy       high in RUN or REPORT
// -----------------------------------------------------------------------------
module loa_error_monitor #(
  parameter int W      = 32,
  parameter int M      = 16,
  parameter int LOG2_N = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [W-1:0]        a,
  input  logic [W-1:0]        b,
  output logic                rpt_valid,
  input  logic                rpt_ready,
  output logic [LOG2_N:0]     err_count,
  output logic [W+LOG2_N-1:0] ed_sum,
  output logic [W-1:0]        ed_max,
  output logic                busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_REPORT = 2'd2
  } state_t;

  // Sample count of the last sample in a window (N-1).
  localparam logic [LOG2_N:0] CNT_LAST = (LOG2_N+1)'((1 << LOG2_N) - 1);

  state_t                state_r;
  state_t                state_nxt_s;

  logic [LOG2_N:0]       cnt_r;
  logic [LOG2_N:0]       err_count_r;
  logic [W+LOG2_N-1:0]   ed_sum_r;
  logic [W-1:0]          ed_max_r;

  logic [W-1:0]          exact_s;
  logic [M-1:0]          approx_lo_s;
  logic [W-M-1:0]        approx_hi_s;
  logic [W-1:0]          approx_s;
  logic                  carry_m_s;
  logic [W-1:0]          ed_s;
  logic                  ed_nz_s;

  logic                  accept_s;
  logic                  clear_s;
  logic                  last_s;

  // ---------------------------------------------------------------------------
  // Per-sample arithmetic
  // ---------------------------------------------------------------------------

  // Exact and LOA sums, both truncated to W bits, and their absolute distance.
  always_comb begin
    exact_s     = a + b;
    approx_lo_s = a[M-1:0] | b[M-1:0];
    // The LOA injects the AND of the top OR-region bits as the carry into
    // the exact upper adder.
    carry_m_s   = a[M-1] & b[M-1];
    approx_hi_s = a[W-1:M] + b[W-1:M] + (W-M)'(carry_m_s);
    approx_s    = {approx_hi_s, approx_lo_s};
    if (exact_s >= approx_s) begin
      ed_s = exact_s - approx_s;
    end else begin
      ed_s = approx_s - exact_s;
    end
    ed_nz_s = (ed_s != {W{1'b0}});
  end

  // ---------------------------------------------------------------------------
  // Control qualifiers
  // ---------------------------------------------------------------------------

  // Handshake qualifiers; abort overrides any sample acceptance in the same
  // cycle.
  always_comb begin
    accept_s = (state_r == ST_RUN) & in_valid & ~abort;
    clear_s  = (state_r == ST_IDLE) & start;
    last_s   = (cnt_r == CNT_LAST);
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; abort wins over every other request outside IDLE.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_nxt_s = ST_IDLE;
        end else if (accept_s && last_s) begin
          state_nxt_s = ST_REPORT;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_REPORT: begin
        if (abort) begin
          state_nxt_s = ST_IDLE;
        end else if (rpt_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_REPORT;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Output decode; each output is a pure function of the state register.
  always_comb begin
    in_ready  = 1'b0;
    rpt_valid = 1'b0;
    busy      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        in_ready  = 1'b0;
        rpt_valid = 1'b0;
        busy      = 1'b0;
      end
      ST_RUN: begin
        in_ready  = 1'b1;
        rpt_valid = 1'b0;
        busy      = 1'b1;
      end
      ST_REPORT: begin
        in_ready  = 1'b0;
        rpt_valid = 1'b1;
        busy      = 1'b1;
      end
      default: begin
        in_ready  = 1'b0;
        rpt_valid = 1'b0;
        busy      = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Accumulators
  // ---------------------------------------------------------------------------

  // Window statistics. They are cleared only by an honoured start, so after
  // a report or an abort they keep the last window's values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r       <= {(LOG2_N+1){1'b0}};
      err_count_r <= {(LOG2_N+1){1'b0}};
      ed_sum_r    <= {(W+LOG2_N){1'b0}};
      ed_max_r    <= {W{1'b0}};
    end else if (clear_s) begin
      cnt_r       <= {(LOG2_N+1){1'b0}};
      err_count_r <= {(LOG2_N+1){1'b0}};
      ed_sum_r    <= {(W+LOG2_N){1'b0}};
      ed_max_r    <= {W{1'b0}};
    end else if (accept_s) begin
      cnt_r       <= cnt_r + (LOG2_N+1)'(1);
      err_count_r <= err_count_r + (LOG2_N+1)'(ed_nz_s);
      // Widths cover N samples of at most 2^W-1 each, so no saturation.
      ed_sum_r    <= ed_sum_r + (W+LOG2_N)'(ed_s);
      if (ed_s > ed_max_r) begin
        ed_max_r <= ed_s;
      end else begin
        ed_max_r <= ed_max_r;
      end
    end else begin
      cnt_r       <= cnt_r;
      err_count_r <= err_count_r;
      ed_sum_r    <= ed_sum_r;
      ed_max_r    <= ed_max_r;
    end
  end

  // Report outputs come straight from the accumulator registers.
  always_comb begin
    err_count = err_count_r;
    ed_sum    = ed_sum_r;
    ed_max    = ed_max_r;
  end

endmodule
